// File: rtl/tod_pkg.sv
// Shared definitions for the time-of-day clock: write target codes, BCD limits
// and the packed-BCD helper functions used by the core.
package tod_pkg;

  typedef enum logic [2:0] {
    SelSec       = 3'd0,
    SelMin       = 3'd1,
    SelHour      = 3'd2,
    SelAlarmMin  = 3'd3,
    SelAlarmHour = 3'd4
  } tod_sel_e;

  localparam logic [7:0] BcdMax59 = 8'h59;
  localparam logic [7:0] BcdMax23 = 8'h23;
  localparam logic [7:0] BcdNoon  = 8'h12;

  // Increment a packed BCD value, wrapping to 00 once it reaches lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim) begin
      r = 8'h00;
    end else if (v[3:0] == 4'h9) begin
      r = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9) && (v <= lim);
  endfunction

  // 24 h BCD hour to the 12 h display form.
  function automatic logic [7:0] to12h(input logic [7:0] h);
    logic [7:0] r;
    case (h)
      8'h00:   r = 8'h12;
      8'h13:   r = 8'h01;
      8'h14:   r = 8'h02;
      8'h15:   r = 8'h03;
      8'h16:   r = 8'h04;
      8'h17:   r = 8'h05;
      8'h18:   r = 8'h06;
      8'h19:   r = 8'h07;
      8'h20:   r = 8'h08;
      8'h21:   r = 8'h09;
      8'h22:   r = 8'h10;
      8'h23:   r = 8'h11;
      default: r = h;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tod_prescaler.sv
// One-second prescaler: counts enabled cycles and flags an advance on wrap,
// or on every enabled cycle in fast mode.
module tod_prescaler #(
  parameter int unsigned PRESCALE   = 10000000,
  parameter int unsigned PRESCALE_W = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic fast,
  input  logic clear,
  output logic advance
);

  localparam logic [PRESCALE_W-1:0] Last = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  wrap;

  always_comb begin
    wrap    = en && (cnt_q == Last);
    advance = en && (wrap || fast);
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tod_clock_core.sv
// Time-of-day clock with packed-BCD hh:mm:ss held in 24 h form, a 12/24 h
// display view, validated register writes and a sticky alarm.
module tod_clock_core
  import tod_pkg::*;
#(
  parameter int unsigned PRESCALE   = 10000000,
  parameter int unsigned PRESCALE_W = $clog2(PRESCALE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fast,
  input  logic       mode24,
  input  logic       set_valid,
  input  logic [2:0] set_sel,
  input  logic [7:0] set_data,
  input  logic       alarm_en,
  input  logic       alarm_clr,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       pm,
  output logic       tick,
  output logic       alarm,
  output logic       set_err
);

  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] alm_min_q, alm_min_d;
  logic [7:0] alm_hour_q, alm_hour_d;
  logic       tick_q, tick_d;
  logic       alarm_q, alarm_d;
  logic       set_err_q, set_err_d;

  tod_sel_e   sel;
  logic       wr_ok;
  logic       advance;
  logic [7:0] sec_nx, min_nx, hour_nx;
  logic       match;

  assign sel = tod_sel_e'(set_sel);

  always_comb begin
    wr_ok = 1'b0;
    case (sel)
      SelSec, SelMin, SelAlarmMin: wr_ok = bcd_valid(set_data, BcdMax59);
      SelHour, SelAlarmHour:       wr_ok = bcd_valid(set_data, BcdMax23);
      default:                     wr_ok = 1'b0;
    endcase
  end

  // Any write cycle freezes the prescaler; only an accepted one restarts it.
  tod_prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en && !set_valid),
    .fast    (fast),
    .clear   (set_valid && wr_ok),
    .advance (advance)
  );

  always_comb begin
    sec_nx  = bcd_inc(sec_q, BcdMax59);
    min_nx  = (sec_q == BcdMax59) ? bcd_inc(min_q, BcdMax59) : min_q;
    hour_nx = (sec_q == BcdMax59 && min_q == BcdMax59) ? bcd_inc(hour_q, BcdMax23) : hour_q;
    match   = alarm_en && advance && (hour_nx == alm_hour_q) && (min_nx == alm_min_q) &&
              (sec_nx == 8'h00);
  end

  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    tick_d     = 1'b0;
    set_err_d  = 1'b0;
    alarm_d    = alarm_q;

    if (set_valid) begin
      if (wr_ok) begin
        case (sel)
          SelSec:       sec_d      = set_data;
          SelMin:       min_d      = set_data;
          SelHour:      hour_d     = set_data;
          SelAlarmMin:  alm_min_d  = set_data;
          SelAlarmHour: alm_hour_d = set_data;
          default:      ;
        endcase
      end else begin
        set_err_d = 1'b1;
      end
    end else if (advance) begin
      sec_d  = sec_nx;
      min_d  = min_nx;
      hour_d = hour_nx;
      tick_d = 1'b1;
    end

    // A match beats a simultaneous clear; disarming beats both.
    if (!alarm_en) begin
      alarm_d = 1'b0;
    end else if (match) begin
      alarm_d = 1'b1;
    end else if (alarm_clr) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      alm_min_q  <= 8'h00;
      alm_hour_q <= 8'h00;
      tick_q     <= 1'b0;
      alarm_q    <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      tick_q     <= tick_d;
      alarm_q    <= alarm_d;
      set_err_q  <= set_err_d;
    end
  end

  assign sec     = sec_q;
  assign min     = min_q;
  assign hour    = mode24 ? hour_q : to12h(hour_q);
  assign pm      = (hour_q >= BcdNoon);
  assign tick    = tick_q;
  assign alarm   = alarm_q;
  assign set_err = set_err_q;

endmodule

// File: tb/tb_tod_clock_core.sv
// Scoreboard bench for tod_clock_core with PRESCALE=4: stimulus queues expected
// observations, a monitor pops them on tick/set_err pulses or snapshot requests.
module tb_tod_clock_core;
  import tod_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fast = 1'b0;
  logic       mode24 = 1'b1;
  logic       set_valid = 1'b0;
  logic [2:0] set_sel = 3'd0;
  logic [7:0] set_data = 8'h00;
  logic       alarm_en = 1'b0;
  logic       alarm_clr = 1'b0;
  logic [7:0] sec, min, hour;
  logic       pm, tick, alarm, set_err;

  tod_clock_core #(
    .PRESCALE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fast      (fast),
    .mode24    (mode24),
    .set_valid (set_valid),
    .set_sel   (set_sel),
    .set_data  (set_data),
    .alarm_en  (alarm_en),
    .alarm_clr (alarm_clr),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .pm        (pm),
    .tick      (tick),
    .alarm     (alarm),
    .set_err   (set_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic       err;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       pm;
    logic       alarm;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   snap_cnt = 0;
  bit   done = 1'b0;

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input string tag, input logic t, input logic e, input logic [7:0] s,
                           input logic [7:0] m, input logic [7:0] h, input logic p,
                           input logic a);
    exp_t x;
    x.tag = tag;
    x.v   = {t, e, s, m, h, p, a};
    q.push_back(x);
  endtask

  // Request a comparison at the next falling edge with no pulse expected.
  task automatic snap(input string tag, input logic [7:0] s, input logic [7:0] m,
                      input logic [7:0] h, input logic p, input logic a);
    expect_ev(tag, 1'b0, 1'b0, s, m, h, p, a);
    snap_cnt++;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    set_sel   = sel;
    set_data  = d;
    set_valid = 1'b1;
    tk(1);
    set_valid = 1'b0;
  endtask

  initial begin : monitor
    int   snap_done;
    int   drain;
    obs_t got;
    exp_t x;
    snap_done = 0;
    drain     = 0;
    forever begin
      @(negedge clk);
      got = {tick, set_err, sec, min, hour, pm, alarm};
      if (tick === 1'b1 || set_err === 1'b1 || snap_cnt != snap_done) begin
        if (tick !== 1'b1 && set_err !== 1'b1) snap_done++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got tick=%b set_err=%b, required no pulse",
                   tick, set_err);
        end else begin
          x = q.pop_front();
          if (got !== x.v) begin
            bad++;
            $display("FAIL %s: got tick=%b err=%b %h:%h:%h pm=%b alarm=%b, required tick=%b err=%b %h:%h:%h pm=%b alarm=%b",
                     x.tag, got.tick, got.err, got.hour, got.min, got.sec, got.pm, got.alarm,
                     x.v.tick, x.v.err, x.v.hour, x.v.min, x.v.sec, x.v.pm, x.v.alarm);
          end
        end
      end
      if (done) begin
        drain++;
        if (q.size() == 0 || drain > 20) begin
          while (q.size() > 0) begin
            x = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no observation, required tick=%b err=%b %h:%h:%h",
                     x.tag, x.v.tick, x.v.err, x.v.hour, x.v.min, x.v.sec);
          end
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of stimulus, required completion before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    tk(2);
    snap("reset_24h", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(1);
    mode24 = 1'b0;
    snap("reset_12h", 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    tk(1);
    mode24 = 1'b1;

    // Normal counting: ticks every 4 enabled cycles, then frozen with en=0.
    rst = 1'b0;
    en  = 1'b1;
    expect_ev("tick_1", 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_ev("tick_2", 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_ev("tick_3", 1'b1, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(12);
    en = 1'b0;
    tk(6);
    snap("frozen_en0", 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(1);

    // Midnight rollover.
    wr(SelHour, 8'h23);
    wr(SelMin, 8'h59);
    wr(SelSec, 8'h59);
    snap("set_235959", 8'h59, 8'h59, 8'h23, 1'b1, 1'b0);
    tk(1);
    en   = 1'b1;
    fast = 1'b1;
    expect_ev("wrap_midnight", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(1);
    en   = 1'b0;
    fast = 1'b0;
    tk(1);
    mode24 = 1'b0;
    snap("midnight_12h", 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    tk(1);

    // 12 h view and rejected writes.
    wr(SelHour, 8'h13);
    snap("hour13_12h", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    tk(1);
    expect_ev("rej_sec_5a", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    wr(SelSec, 8'h5A);
    expect_ev("rej_sec_60", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    wr(SelSec, 8'h60);
    expect_ev("rej_sel_6", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    wr(3'd6, 8'h00);
    expect_ev("rej_hour_24", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    wr(SelHour, 8'h24);
    expect_ev("rej_min_a0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    wr(SelMin, 8'hA0);
    tk(1);

    // Alarm: writes never match; an advance does, and beats alarm_clr.
    mode24   = 1'b1;
    alarm_en = 1'b1;
    wr(SelAlarmHour, 8'h07);
    wr(SelAlarmMin, 8'h30);
    wr(SelHour, 8'h07);
    wr(SelMin, 8'h30);
    wr(SelSec, 8'h00);
    snap("write_no_match", 8'h00, 8'h30, 8'h07, 1'b0, 1'b0);
    tk(1);
    wr(SelMin, 8'h29);
    wr(SelSec, 8'h59);
    en        = 1'b1;
    fast      = 1'b1;
    alarm_clr = 1'b1;
    expect_ev("alarm_set", 1'b1, 1'b0, 8'h00, 8'h30, 8'h07, 1'b0, 1'b1);
    tk(1);
    en   = 1'b0;
    fast = 1'b0;
    tk(1);
    alarm_clr = 1'b0;
    snap("alarm_cleared", 8'h00, 8'h30, 8'h07, 1'b0, 1'b0);
    tk(1);

    // Write landing on a prescaler wrap.
    wr(SelSec, 8'h10);
    en = 1'b1;
    tk(3);
    wr(SelSec, 8'h20);
    tk(3);
    snap("no_tick_on_write", 8'h20, 8'h30, 8'h07, 1'b0, 1'b0);
    expect_ev("tick_after_write", 1'b1, 1'b0, 8'h21, 8'h30, 8'h07, 1'b0, 1'b0);
    tk(1);
    en = 1'b0;
    tk(1);

    // Reset mid-count.
    wr(SelHour, 8'h12);
    wr(SelMin, 8'h34);
    wr(SelSec, 8'h56);
    snap("set_123456", 8'h56, 8'h34, 8'h12, 1'b1, 1'b0);
    tk(1);
    en = 1'b1;
    tk(2);
    rst = 1'b1;
    tk(1);
    rst = 1'b0;
    snap("mid_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(3);
    snap("no_early_tick", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_ev("tick_after_reset", 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    tk(1);
    en = 1'b0;
    tk(1);
    done = 1'b1;
  end

endmodule
